// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: machine word, fetch FSM states, PC step.
// No logic; imported by fetch_unit and fetch_queue.
package fetch_unit_pkg;

  typedef logic [31:0] cpu_word;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state;

  localparam int unsigned CPU_PC_STEP = 4;

endpackage

// File: rtl/fetch_queue.sv
// In-order ring of fetch slots {pc, data, filled}: allocated at request, filled at response, popped at head.
// Head outputs come straight from registers (zero added latency); flush empties the ring in one cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  cpu_word       alloc_pc,
  input  logic          fill,
  input  cpu_word       fill_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] occupancy,
  output logic [CW-1:0] unfilled_count,
  output cpu_word       head_pc,
  output cpu_word       head_data,
  output logic          head_filled
);

  cpu_word          pc_q   [DEPTH];
  cpu_word          data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] filled_d;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW-1:0]    fill_q;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    unf_q;

  // Pop and fill never target the same slot: fill only lands on the oldest unfilled entry.
  always_comb begin
    filled_d = filled_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((pop && head_q == PW'(i)) || (alloc && tail_q == PW'(i))) filled_d[i] = 1'b0;
      if (fill && fill_q == PW'(i)) filled_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      occ_q    <= '0;
      unf_q    <= '0;
    end else if (flush) begin
      filled_q <= '0;
      head_q   <= tail_q;
      fill_q   <= tail_q;
      occ_q    <= '0;
      unf_q    <= '0;
    end else begin
      if (alloc) begin
        pc_q[tail_q] <= alloc_pc;
        tail_q       <= tail_q + 1'b1;
      end
      if (fill) begin
        data_q[fill_q] <= fill_data;
        fill_q         <= fill_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      filled_q <= filled_d;
      occ_q    <= occ_q + CW'(alloc) - CW'(pop);
      unf_q    <= unf_q + CW'(alloc) - CW'(fill);
    end
  end

  assign occupancy      = occ_q;
  assign unfilled_count = unf_q;
  assign head_pc        = pc_q[head_q];
  assign head_data      = data_q[head_q];
  assign head_filled    = filled_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word reads, feeds the decoder in order; redirect/halt flush.
// Instruction visible 1 cycle after its response; a same-cycle decoder pop frees a request credit.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter cpu_word     RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int unsigned PC_STEP  = CPU_PC_STEP
) (
  input  logic    clk,
  input  logic    rst_n,
  output logic    imemReqValid,
  input  logic    imemReqReady,
  output cpu_word imemReqAddr,
  input  logic    imemRespValid,
  input  cpu_word imemRespData,
  output logic    iValid,
  input  logic    iReady,
  output cpu_word iReg,
  output cpu_word iPC,
  input  logic    redirectEn,
  input  cpu_word redirectPC,
  input  logic    halt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = $clog2(2 * DEPTH) + 1;

  fetch_state    state_q;
  cpu_word       fetch_pc_q;
  logic [KW-1:0] kill_q;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] unfilled_count;
  logic [CW-1:0] occ_after;
  logic          running;
  logic          flush;
  logic          pop;
  logic          req_fire;
  logic          fill;
  logic          unused_bits;

  assign running   = rst_n && (state_q == FETCH_RUN);
  assign flush     = running && (redirectEn || halt);
  assign pop       = iValid && iReady;
  assign occ_after = occupancy - CW'(pop);

  assign imemReqValid = running && !redirectEn && !halt && (occ_after < CW'(DEPTH));
  assign imemReqAddr  = {fetch_pc_q[31:2], 2'b00};
  assign req_fire     = imemReqValid && imemReqReady;
  assign fill         = imemRespValid && (kill_q == '0) && !flush;
  assign unused_bits  = ^{redirectPC[1:0], fetch_pc_q[1:0]};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc         (req_fire),
    .alloc_pc      (imemReqAddr),
    .fill          (fill),
    .fill_data     (imemRespData),
    .pop           (pop),
    .flush         (flush),
    .occupancy     (occupancy),
    .unfilled_count(unfilled_count),
    .head_pc       (iPC),
    .head_data     (iReg),
    .head_filled   (iValid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      fetch_pc_q <= RESET_PC;
      kill_q     <= '0;
    end else begin
      // A response arriving on a flush cycle retires either a pending kill or the oldest unfilled slot.
      if (flush) kill_q <= kill_q + KW'(unfilled_count) - KW'(imemRespValid);
      else if (imemRespValid && kill_q != '0) kill_q <= kill_q - 1'b1;

      if (running && halt) state_q <= FETCH_HALTED;

      if (flush) fetch_pc_q <= {redirectPC[31:2], 2'b00};
      else if (req_fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
    end
  end

  // Memory never returns more words than were requested.
  always_ff @(posedge clk) begin
    if (rst_n && imemRespValid && kill_q == '0) assert (unfilled_count != '0);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model and hand-computed expectations.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    imemReqValid, imemReqReady;
  cpu_word imemReqAddr;
  logic    imemRespValid;
  cpu_word imemRespData;
  logic    iValid, iReady;
  cpu_word iReg, iPC;
  logic    redirectEn;
  cpu_word redirectPC;
  logic    halt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .iValid(iValid), .iReady(iReady), .iReg(iReg), .iPC(iPC),
    .redirectEn(redirectEn), .redirectPC(redirectPC), .halt(halt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] req_cyc[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_dat[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: logs request/pop handshakes, clocks once, drives any due response.
  task automatic tick();
    #1;
    if (imemReqValid && imemReqReady) begin
      req_log.push_back(imemReqAddr);
      req_cyc.push_back(32'(cyc));
      pend_addr.push_back(imemReqAddr);
      pend_due.push_back(cyc + mem_lat);
    end
    if (iValid && iReady) begin
      got_pc.push_back(iPC);
      got_dat.push_back(iReg);
    end
    @(posedge clk);
    cyc++;
    #1;
    imemRespValid = 1'b0;
    imemRespData  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirectEn = 1'b0; redirectPC = '0; halt = 1'b0;
    iReady = 1'b1; imemReqReady = 1'b1;
    imemRespValid = 1'b0; imemRespData = '0;
    pend_addr.delete(); pend_due.delete();
    req_log.delete(); req_cyc.delete();
    got_pc.delete(); got_dat.delete();
    #1;
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int stale, nreq, niv;

    // Reset values, then sequential fetch with 1-cycle memory
    do_reset();
    check("rst_req_vld", imemReqValid, 0);
    check("rst_ivalid", iValid, 0);
    check("rst_ireg", iReg, 0);
    check("rst_ipc", iPC, 0);
    release_rst();
    mem_lat = 1;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_req_addr%0d", i), qat(req_log, i), 32'(i * 4));
      check($sformatf("t1_req_cyc%0d", i), qat(req_cyc, i), 32'(i));
      check($sformatf("t1_ipc%0d", i), qat(got_pc, i), 32'(i * 4));
      check($sformatf("t1_ireg%0d", i), qat(got_dat, i), mem_word(32'(i * 4)));
    end

    // Decoder stall: credit limits to DEPTH requests, head held stable
    do_reset();
    release_rst();
    iReady = 1'b0;
    repeat (3) tick();
    check("t2_ipc_mid", iPC, 32'h0);
    check("t2_ireg_mid", iReg, mem_word(32'h0));
    repeat (2) tick();
    #1;
    check("t2_nreq", req_log.size(), 2);
    check("t2_req_vld_blocked", imemReqValid, 0);
    check("t2_ivalid", iValid, 1);
    check("t2_ipc_end", iPC, 32'h0);
    check("t2_ireg_end", iReg, mem_word(32'h0));
    iReady = 1'b1;
    #1;
    check("t2_req_vld_on_pop", imemReqValid, 1);
    check("t2_req_addr_on_pop", imemReqAddr, 32'h8);
    do_reset();
    check("t2_midrst_ivalid", iValid, 0);
    check("t2_midrst_ipc", iPC, 0);
    check("t2_midrst_ireg", iReg, 0);

    // Redirect with two requests in flight (3-cycle memory)
    release_rst();
    mem_lat = 3;
    repeat (2) tick();
    check("t3_nreq_pre", req_log.size(), 2);
    redirectEn = 1'b1; redirectPC = 32'h0000_0103;
    #1;
    check("t3_no_req_on_redirect", imemReqValid, 0);
    tick();
    redirectEn = 1'b0;
    #1;
    check("t3_req_vld_next", imemReqValid, 1);
    check("t3_req_addr_next", imemReqAddr, 32'h100);
    check("t3_ivalid_after", iValid, 0);
    for (int k = 0; k < 20 && got_pc.size() == 0; k++) tick();
    check("t3_first_ipc", qat(got_pc, 0), 32'h100);
    check("t3_first_ireg", qat(got_dat, 0), mem_word(32'h100));

    // Redirect in the same cycle a response arrives, one more in flight
    do_reset();
    release_rst();
    mem_lat = 2;
    iReady = 1'b0;
    repeat (2) tick();
    redirectEn = 1'b1; redirectPC = 32'h0000_0200;
    tick();
    redirectEn = 1'b0;
    stale = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (iValid) stale++;
      tick();
    end
    #1;
    check("t4_stale_ivalid", stale, 0);
    check("t4_ivalid", iValid, 1);
    check("t4_ipc", iPC, 32'h200);
    check("t4_ireg", iReg, mem_word(32'h200));

    // Halt together with redirect: halt wins, nothing more until reset
    do_reset();
    release_rst();
    mem_lat = 2;
    repeat (2) tick();
    halt = 1'b1; redirectEn = 1'b1; redirectPC = 32'h0000_0300;
    #1;
    check("t5_no_req_on_halt", imemReqValid, 0);
    tick();
    halt = 1'b0; redirectEn = 1'b0;
    nreq = 0; niv = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (imemReqValid) nreq++;
      if (iValid) niv++;
      tick();
    end
    check("t5_req_cycles", nreq, 0);
    check("t5_ivalid_cycles", niv, 0);
    check("t5_nreq", req_log.size(), 2);
    do_reset();
    check("t5_rst_req_vld", imemReqValid, 0);
    release_rst();
    #1;
    check("t5_restart_vld", imemReqValid, 1);
    check("t5_restart_addr", imemReqAddr, 32'h0);

    // Memory not ready: address and PC held until handshake
    do_reset();
    release_rst();
    mem_lat = 1;
    repeat (2) tick();
    imemReqReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t6_hold_addr%0d", k), imemReqAddr, 32'h8);
      check($sformatf("t6_hold_vld%0d", k), imemReqValid, 1);
      tick();
    end
    check("t6_nreq_held", req_log.size(), 2);
    imemReqReady = 1'b1;
    #1;
    check("t6_addr_at_hs", imemReqAddr, 32'h8);
    tick();
    #1;
    check("t6_addr_after_hs", imemReqAddr, 32'hC);
    check("t6_req_log2", qat(req_log, 2), 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
